frame_stream_server: RTL

- Memory-side responder for the streaming 3x3 convolution engine.
- Answers the engine's read_request by supplying source-frame pixels from a dual-port frame RAM. Stores pixels written under write_request into a destination bank.
- Sequences one frame per start pulse: engine reset, run, wait for finished, done pulse.
- Sits between the frame RAM (two banks, ping-pong) and the convolution engine.

---
 rtl/frame_stream_pkg.sv | 23 ++
 rtl/frame_addr_counter.sv | 42 ++++
 rtl/frame_stream_server.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/frame_stream_pkg.sv
// Shared types and default geometry for the frame stream server and its counters.
package frame_stream_pkg;

  localparam int          DEF_FRAME_W     = 640;
  localparam int          DEF_FRAME_H     = 480;
  localparam int          DEF_PIX_W       = 8;
  localparam int          DEF_ADDR_W      = 19;
  localparam int          DEF_ENG_RST_CYC = 2;
  localparam int unsigned DEF_TIMEOUT     = 32'd400000;

  localparam int FRAME_PIXELS = DEF_FRAME_W * DEF_FRAME_H;

  typedef logic [DEF_PIX_W-1:0] pixel_t;

  typedef enum logic [2:0] {
    IDLE,
    ENG_RST,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/frame_addr_counter.sv
// Saturating pixel counter; the exposed address parks on the last pixel once
// the terminal count is reached so an overrunning reader never leaves the frame.
module frame_addr_counter
  import frame_stream_pkg::*;
#(
  parameter int           W   = 20,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-2:0] addr,
  output logic         tc
);

  localparam logic [W-2:0] LAST = (W-1)'(MAX - W'(1));

  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (en && !tc) begin
      count_next = count_reg + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign tc   = (count_reg == MAX);
  assign addr = tc ? LAST : count_reg[W-2:0];

endmodule

// File: rtl/frame_stream_server.sv
// Memory-side responder for the 3x3 convolution engine: streams a source bank
// to the engine, stores its results into the opposite bank, one frame per start.
module frame_stream_server
  import frame_stream_pkg::*;
#(
  parameter int          FRAME_W     = DEF_FRAME_W,
  parameter int          FRAME_H     = DEF_FRAME_H,
  parameter int          PIX_W       = DEF_PIX_W,
  parameter int          ADDR_W      = DEF_ADDR_W,
  parameter int          ENG_RST_CYC = DEF_ENG_RST_CYC,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              src_bank,
  output logic              busy,
  output logic              frame_done,
  output logic              error,
  output logic              conv_reset,
  input  logic              conv_read_request,
  input  logic              conv_write_request,
  input  logic              conv_finished,
  input  logic [PIX_W-1:0]  conv_pixel_o,
  output logic [PIX_W-1:0]  conv_pixel_i,
  output logic [ADDR_W:0]   mem_rd_addr,
  input  logic [PIX_W-1:0]  mem_rd_data,
  output logic [ADDR_W:0]   mem_wr_addr,
  output logic [PIX_W-1:0]  mem_wr_data,
  output logic              mem_wr_en
);

  localparam logic [ADDR_W:0] PIX_MAX  = (ADDR_W+1)'(FRAME_W * FRAME_H);
  localparam int              ENG_W    = (ENG_RST_CYC > 1) ? $clog2(ENG_RST_CYC) : 1;
  localparam logic [ENG_W-1:0] ENG_LAST = ENG_W'(ENG_RST_CYC - 1);

  state_t            state_reg;
  state_t            state_next;
  logic              src_reg;
  logic              error_reg;
  logic              rd_valid_reg;
  logic [31:0]       timer_reg;
  logic [ENG_W-1:0]  eng_cnt_reg;

  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd_tc;
  logic              wr_tc;

  logic start_acc;
  logic in_active;
  logic rd_acc;
  logic wr_acc;
  logic timeout_hit;

  assign start_acc   = (state_reg == IDLE) && start;
  assign in_active   = (state_reg == RUN) || (state_reg == DRAIN);
  assign rd_acc      = conv_read_request && (state_reg == RUN);
  assign wr_acc      = conv_write_request && in_active;
  assign timeout_hit = in_active && (timer_reg == TIMEOUT - 32'd1);

  frame_addr_counter #(.W(ADDR_W + 1), .MAX(PIX_MAX)) u_rd_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (start_acc),
    .en      (rd_acc),
    .addr    (rd_addr),
    .tc      (rd_tc)
  );

  frame_addr_counter #(.W(ADDR_W + 1), .MAX(PIX_MAX)) u_wr_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (start_acc),
    .en      (wr_acc),
    .addr    (wr_addr),
    .tc      (wr_tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = ENG_RST;
      ENG_RST: if (eng_cnt_reg == ENG_LAST) state_next = RUN;
      RUN: begin
        if (timeout_hit) state_next = DONE;
        else if (wr_tc)  state_next = DRAIN;
      end
      DRAIN:   if (timeout_hit || conv_finished) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_reg != IDLE);
    frame_done = (state_reg == DONE);
    conv_reset = !in_active;
    mem_wr_en  = wr_acc && !wr_tc;
  end

  // Frame bookkeeping; a new start wipes the previous frame's error and counts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_reg      <= 1'b0;
      error_reg    <= 1'b0;
      rd_valid_reg <= 1'b0;
      timer_reg    <= '0;
      eng_cnt_reg  <= '0;
    end else begin
      rd_valid_reg <= rd_acc;
      if (start_acc) begin
        src_reg     <= src_bank;
        error_reg   <= 1'b0;
        timer_reg   <= '0;
        eng_cnt_reg <= '0;
      end else begin
        if ((rd_acc && rd_tc) || (wr_acc && wr_tc) || timeout_hit) begin
          error_reg <= 1'b1;
        end
        if (in_active) begin
          timer_reg <= timer_reg + 32'd1;
        end
        if (state_reg == ENG_RST) begin
          eng_cnt_reg <= eng_cnt_reg + ENG_W'(1);
        end
      end
    end
  end

  assign error        = error_reg;
  assign mem_rd_addr  = {src_reg, rd_addr};
  assign mem_wr_addr  = {~src_reg, wr_addr};
  assign mem_wr_data  = conv_pixel_o;
  assign conv_pixel_i = rd_valid_reg ? mem_rd_data : '0;

endmodule
